// File: rtl/ysyx_22041071_mem_arb_if.sv
// Bundle of the IF/LS request-response channels and the RAMHelper port.
// The slave modport faces the arbiter; the master modport faces the pipeline/RAM side.
interface ysyx_22041071_mem_arb_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_req_addr;
    logic        if_rsp_valid;
    logic        if_rsp_ready;
    logic [63:0] if_rsp_rdata;

    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [63:0] ls_req_addr;
    logic        ls_req_wen;
    logic [63:0] ls_req_wdata;
    logic [63:0] ls_req_wmask;
    logic        ls_rsp_valid;
    logic        ls_rsp_ready;
    logic [63:0] ls_rsp_rdata;

    logic        ram_en;
    logic [63:0] ram_rIdx;
    logic [63:0] ram_rdata;
    logic [63:0] ram_wIdx;
    logic [63:0] ram_wdata;
    logic [63:0] ram_wmask;
    logic        ram_wen;

    modport slave (
        input  if_req_valid, if_req_addr, if_rsp_ready,
        input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_rsp_ready,
        input  ram_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        output ram_en, ram_rIdx, ram_wIdx, ram_wdata, ram_wmask, ram_wen
    );

    modport master (
        output if_req_valid, if_req_addr, if_rsp_ready,
        output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_rsp_ready,
        output ram_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        input  ram_en, ram_rIdx, ram_wIdx, ram_wdata, ram_wmask, ram_wen
    );
endinterface

// File: rtl/ysyx_22041071_mem_arb.sv
// Shares the single RAMHelper port between instruction fetch and load/store,
// one outstanding transaction at a time, with IF starvation protection and fetch flush.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no transaction; grant decided combinationally, RAM driven
// S_WAIT | RAM read data arriving; captured into the response buffer
// S_RESP | response buffer presented to the owner until it is accepted
module ysyx_22041071_mem_arb #(
    parameter logic [63:0] START_ADDR   = 64'h8000_0000,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_flush,
    ysyx_22041071_mem_arb_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner_ls;
    logic        r_is_wr;
    logic [2:0]  r_starve;
    logic [63:0] r_buf;

    logic        w_gnt_if;
    logic        w_gnt_ls;
    logic        w_gnt;
    logic        w_if_flushed;
    logic [63:0] w_addr;
    logic [63:0] w_idx;

    // IF wins a tie only once LS has starved it; a flush blocks IF outright.
    always_comb begin
        w_gnt_if = 1'b0;
        w_gnt_ls = 1'b0;
        if ((r_state == S_IDLE) && i_reset) begin
            if (bus.if_req_valid && !i_flush && (!bus.ls_req_valid || (r_starve == LIMIT))) begin
                w_gnt_if = 1'b1;
            end else if (bus.ls_req_valid) begin
                w_gnt_ls = 1'b1;
            end
        end
    end

    assign w_gnt        = w_gnt_if | w_gnt_ls;
    assign w_addr       = w_gnt_ls ? bus.ls_req_addr : bus.if_req_addr;
    assign w_idx        = (w_addr - START_ADDR) >> 3;
    assign w_if_flushed = !r_owner_ls && i_flush;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_state_nxt = w_if_flushed ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                if (w_if_flushed) begin
                    w_state_nxt = S_IDLE;
                end else if (r_owner_ls ? bus.ls_rsp_ready : bus.if_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // RAM is only driven in the grant cycle; a write commits on that edge.
    always_comb begin
        bus.if_req_ready = w_gnt_if;
        bus.ls_req_ready = w_gnt_ls;
        bus.if_rsp_valid = (r_state == S_RESP) && !r_owner_ls && !i_flush;
        bus.ls_rsp_valid = (r_state == S_RESP) && r_owner_ls;
        bus.if_rsp_rdata = r_buf;
        bus.ls_rsp_rdata = r_buf;
        bus.ram_en       = w_gnt;
        bus.ram_rIdx     = w_gnt ? w_idx : 64'd0;
        bus.ram_wIdx     = w_gnt ? w_idx : 64'd0;
        bus.ram_wen      = w_gnt_ls && bus.ls_req_wen;
        bus.ram_wdata    = w_gnt_ls ? bus.ls_req_wdata : 64'd0;
        bus.ram_wmask    = w_gnt_ls ? bus.ls_req_wmask : 64'd0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_owner_ls <= 1'b0;
            r_is_wr    <= 1'b0;
            r_starve   <= 3'd0;
            r_buf      <= 64'd0;
        end else begin
            if (w_gnt) begin
                r_owner_ls <= w_gnt_ls;
                r_is_wr    <= w_gnt_ls && bus.ls_req_wen;
            end
            if (w_gnt_if) begin
                r_starve <= 3'd0;
            end else if (w_gnt_ls && bus.if_req_valid && (r_starve < LIMIT)) begin
                r_starve <= r_starve + 3'd1;
            end
            if ((r_state == S_WAIT) && !w_if_flushed) begin
                r_buf <= r_is_wr ? 64'd0 : bus.ram_rdata;
            end
        end
    end

endmodule

// File: doc/ysyx_22041071_mem_arb.md
# ysyx_22041071_mem_arb

Arbitrates the single RAMHelper memory port between the instruction-fetch requester (IF) and the load/store requester (LS). Accepts valid/ready requests from both, converts byte addresses to 64-bit word indices, drives the RAM port, and returns the registered read data on a per-requester valid/ready response channel. Fetch responses can be squashed by a branch-redirect flush. Sits between the IF/MEM pipeline stages and the RAMHelper instance.

## Interface
- START_ADDR, 64'h8000_0000: base byte address of RAM; word index = (addr - START_ADDR) >> 3.
- STARVE_LIMIT, 4: consecutive LS grants taken while IF waits before IF is forced to win; 3-bit counter, legal 1..7.

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  branch redirect; squashes pending/outstanding IF transaction
- if_req_valid  in  1  / if_req_ready  out  1  / if_req_addr  in  64  fetch request
- if_rsp_valid  out  1  / if_rsp_ready  in  1  / if_rsp_rdata  out  64  fetch response (full 64-bit word)
- ls_req_valid  in  1  / ls_req_ready  out  1  / ls_req_addr  in  64  LS request
- ls_req_wen  in  1  / ls_req_wdata  in  64  / ls_req_wmask  in  64  write qualifiers (wmask bit-granular)
- ls_rsp_valid  out  1  / ls_rsp_ready  in  1  / ls_rsp_rdata  out  64  LS response
- ram_en  out  1  / ram_rIdx  out  64  / ram_rdata  in  64  RAM read port (data returned one edge after index)
- ram_wIdx  out  64  / ram_wdata  out  64  / ram_wmask  out  64  / ram_wen  out  1  RAM write port

## Operation
- FSM states: IDLE, WAIT, RESP. One outstanding transaction maximum; owner register (IF/LS) set on grant.
- IDLE: grant decision combinational. Only one valid -> that requester. Both valid -> LS, unless starve_cnt == STARVE_LIMIT -> IF. flush high -> IF never granted that cycle (if_req_ready = 0).
- req_ready = (state == IDLE) & granted-to-this-requester & reset deasserted. Handshake = valid & ready -> IDLE->WAIT.
- RAM drive on grant cycle only: ram_en = 1, ram_rIdx = ram_wIdx = (addr - START_ADDR) >> 3 (64-bit subtract, modulo 2^64); ram_wen = ls_req_wen for LS grant, 0 for IF; wdata/wmask pass through. All RAM outputs 0 when no grant.
- WAIT: capture ram_rdata into response buffer (forced to 0 for writes) -> RESP. If owner IF and flush high -> discard, -> IDLE.
- RESP: owner's rsp_valid = 1, rdata = buffer, held stable until owner's rsp_ready; then -> IDLE. If owner IF and flush high -> rsp_valid drops, -> IDLE, no response delivered.
- flush never affects LS transactions; an LS write commits on the grant edge regardless.
- starve_cnt: +1 (saturating at STARVE_LIMIT) on LS grant while if_req_valid high; cleared on IF grant; unchanged otherwise.
- Address below START_ADDR or beyond RAM size: no checking; index wraps as computed.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, owner IF, starve_cnt 0, buffer 0; all req_ready, rsp_valid, ram_en, ram_wen 0; RAM index/data/mask outputs 0.
- Grant cycle T; RAM write commits at edge ending T; read data valid during T+1; rsp_valid first high in T+2.
- Minimum transaction 3 cycles (T grant, T+1 WAIT, T+2 RESP accepted); next grant earliest T+3. Peak throughput 1 per 3 cycles.
- rsp_valid never depends combinationally on rsp_ready; req_ready depends combinationally on both req_valid and flush.
- flush in the same cycle as rsp_ready in RESP: flush wins, IF sees no handshake.
- Reset mid-transaction: transaction abandoned, no response; a write granted before the reset edge stays committed.

## Test plan
- IF only, addr 64'h8000_0010 -> ram_rIdx = 2 in T, if_rsp_valid in T+2 with RAM word 2; if_rsp_ready held low 3 cycles -> rdata stable, valid stays 1.
- LS write addr 64'h8000_0008, wdata 64'hDEAD_BEEF, wmask all-ones -> ram_wen = 1, wIdx = 1 in T; ls_rsp_rdata = 0; later IF read of same addr returns 64'hDEAD_BEEF.
- Both valid continuously, STARVE_LIMIT = 4 -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- IF granted, flush in WAIT -> no if_rsp_valid, IDLE next cycle; repeat with flush in RESP -> if_rsp_valid drops same cycle.
- flush high in IDLE with both valid and starve_cnt = STARVE_LIMIT -> if_req_ready = 0, LS granted instead.
- reset pulsed low during RESP -> all outputs 0 immediately, starve_cnt 0, next request granted normally after release.
